// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and read-address generation for the NTT controller.
package ntt_pkg;

   localparam int unsigned N      = 256;
   localparam int unsigned LAYERS = 7;
   localparam int unsigned PAIRS  = 128;

   localparam logic [1:0] MODE_NTT  = 2'b00;
   localparam logic [1:0] MODE_INTT = 2'b01;
   localparam logic [1:0] MODE_IDLE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } ntt_state_t;

   typedef struct packed {
      logic [7:0] addr_a;
      logic [7:0] addr_b;
      logic [6:0] tw;
   } rd_op_t;

   // Forward walks butterfly spans 128..2 (Cooley-Tukey); inverse walks 2..128 (Gentleman-Sande).
   function automatic rd_op_t calc_op(input logic inv, input logic [2:0] layer,
                                      input logic [6:0] pair);
      int unsigned l, p, len, g, a, tw;
      rd_op_t      op;
      l = {29'd0, layer};
      p = {25'd0, pair};
      if (!inv) begin
         len = 32'd128 >> l;
         g   = p >> (32'd7 - l);
         tw  = (32'd1 << l) + g;
      end else begin
         len = 32'd2 << l;
         g   = p >> (l + 32'd1);
         tw  = (32'd128 >> l) - 32'd1 - g;
      end
      a         = ((g * len) << 1) + (p & (len - 32'd1));
      op.addr_a = 8'(a);
      op.addr_b = 8'(a + len);
      op.tw     = 7'(tw);
      return op;
   endfunction

endpackage

// File: rtl/ntt_wb_pipe.sv
// Fixed-depth delay line turning read strobes/addresses into write strobes/addresses.
module ntt_wb_pipe
   import ntt_pkg::*;
#(
   parameter int unsigned DEPTH = 5,
   parameter int unsigned AW    = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr_a,
   input  logic [AW-1:0] in_addr_b,
   output logic          out_valid,
   output logic [AW-1:0] out_addr_a,
   output logic [AW-1:0] out_addr_b
);

   logic [2*AW:0] stage [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= {in_valid, in_addr_a, in_addr_b};
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign {out_valid, out_addr_a, out_addr_b} = stage[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// Sequences the 7 layers x 128 butterflies of a 256-point NTT/INTT over a
// coefficient memory, with a write-back delay line matched to read+butterfly latency.
module ntt_ctrl
   import ntt_pkg::*;
#(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned BF_LAT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       inv,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic [1:0] bf_mode,
   output logic       rd_en,
   output logic [7:0] rd_addr_a,
   output logic [7:0] rd_addr_b,
   output logic [6:0] tw_idx,
   output logic       wr_en,
   output logic [7:0] wr_addr_a,
   output logic [7:0] wr_addr_b
);

   localparam int unsigned PIPE = RD_LAT + BF_LAT;
   localparam int unsigned DW   = $clog2(PIPE + 1);

   ntt_state_t    state, nxt_state;
   logic [2:0]    layer, nxt_layer;
   logic [6:0]    pair, nxt_pair;
   logic [DW-1:0] drain_cnt, nxt_drain_cnt;
   logic          inv_q, nxt_inv;
   logic          take_abort;
   logic          nxt_run, nxt_busy;
   rd_op_t        nxt_op;

   assign take_abort = abort && (state == S_RUN || state == S_DRAIN);

   always_comb begin
      nxt_state     = state;
      nxt_layer     = layer;
      nxt_pair      = pair;
      nxt_drain_cnt = drain_cnt;
      nxt_inv       = inv_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               nxt_state = S_RUN;
               nxt_layer = '0;
               nxt_pair  = '0;
               nxt_inv   = inv;
            end
         end
         S_RUN: begin
            if (take_abort) begin
               nxt_state = S_IDLE;
            end else if (pair == 7'(PAIRS - 1)) begin
               nxt_state     = S_DRAIN;
               nxt_drain_cnt = '0;
            end else begin
               nxt_pair = pair + 7'd1;
            end
         end
         S_DRAIN: begin
            if (take_abort) begin
               nxt_state = S_IDLE;
            end else if (drain_cnt == DW'(PIPE - 1)) begin
               if (layer == 3'(LAYERS - 1)) begin
                  nxt_state = S_DONE;
               end else begin
                  nxt_state = S_RUN;
                  nxt_layer = layer + 3'd1;
                  nxt_pair  = '0;
               end
            end else begin
               nxt_drain_cnt = drain_cnt + DW'(1);
            end
         end
         S_DONE:  nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state decode so rd_en lines up with the new pair.
   assign nxt_run  = (nxt_state == S_RUN);
   assign nxt_busy = (nxt_state == S_RUN) || (nxt_state == S_DRAIN);
   assign nxt_op   = calc_op(nxt_inv, nxt_layer, nxt_pair);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         layer     <= '0;
         pair      <= '0;
         drain_cnt <= '0;
         inv_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bf_mode   <= MODE_IDLE;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_idx    <= '0;
      end else begin
         state     <= nxt_state;
         layer     <= nxt_layer;
         pair      <= nxt_pair;
         drain_cnt <= nxt_drain_cnt;
         inv_q     <= nxt_inv;
         busy      <= nxt_busy;
         done      <= (nxt_state == S_DONE);
         bf_mode   <= nxt_busy ? (nxt_inv ? MODE_INTT : MODE_NTT) : MODE_IDLE;
         rd_en     <= nxt_run;
         rd_addr_a <= nxt_run ? nxt_op.addr_a : '0;
         rd_addr_b <= nxt_run ? nxt_op.addr_b : '0;
         tw_idx    <= nxt_run ? nxt_op.tw : '0;
      end
   end

   ntt_wb_pipe #(
      .DEPTH(PIPE),
      .AW   (8)
   ) u_wb_pipe (
      .clk       (clk),
      .rst       (rst),
      .clr       (take_abort),
      .in_valid  (rd_en),
      .in_addr_a (rd_addr_a),
      .in_addr_b (rd_addr_b),
      .out_valid (wr_en),
      .out_addr_a(wr_addr_a),
      .out_addr_b(wr_addr_b)
   );

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed checks of the NTT controller: sequencing, address tables, abort and async reset.
module tb_ntt_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, inv, abort;
   logic       busy, done, rd_en, wr_en;
   logic [1:0] bf_mode;
   logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [6:0] tw_idx;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int run; int cyc;
      int rd;  int a;  int b;  int tw;
      int wr;  int wa; int wb;
      int busy; int done; int mode;
   } vec_t;

   vec_t tbl[$];

   ntt_ctrl #(.RD_LAT(1), .BF_LAT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .inv      (inv),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .bf_mode  (bf_mode),
      .rd_en    (rd_en),
      .rd_addr_a(rd_addr_a),
      .rd_addr_b(rd_addr_b),
      .tw_idx   (tw_idx),
      .wr_en    (wr_en),
      .wr_addr_a(wr_addr_a),
      .wr_addr_b(wr_addr_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(int run, int c, int rd, int a, int b, int tw, int wr,
                               int wa, int wb, int bz, int dn, int md);
      vec_t v;
      v.run = run; v.cyc = c; v.rd = rd; v.a = a; v.b = b; v.tw = tw;
      v.wr = wr; v.wa = wa; v.wb = wb; v.busy = bz; v.done = dn; v.mode = md;
      return v;
   endfunction

   task automatic check_vec(input vec_t v, input string tag);
      chk({tag, ".rd_en"},     int'(rd_en),     v.rd);
      chk({tag, ".rd_addr_a"}, int'(rd_addr_a), v.a);
      chk({tag, ".rd_addr_b"}, int'(rd_addr_b), v.b);
      chk({tag, ".tw_idx"},    int'(tw_idx),    v.tw);
      chk({tag, ".wr_en"},     int'(wr_en),     v.wr);
      chk({tag, ".wr_addr_a"}, int'(wr_addr_a), v.wa);
      chk({tag, ".wr_addr_b"}, int'(wr_addr_b), v.wb);
      chk({tag, ".busy"},      int'(busy),      v.busy);
      chk({tag, ".done"},      int'(done),      v.done);
      chk({tag, ".bf_mode"},   int'(bf_mode),   v.mode);
   endtask

   // Full transform with table checkpoints, per-layer write scoreboard and repeated-start noise.
   task automatic do_run(input int id, input logic inv_v);
      bit [255:0] seen = '0;
      int wcnt = 0, dup = 0, bad_mode = 0, done_cyc = -1, done_cnt = 0;
      string tag;
      cyc   = 0;
      start = 1'b1;
      inv   = inv_v;
      tick();
      start = 1'b0;
      while (cyc <= 940) begin
         foreach (tbl[i]) begin
            if (tbl[i].run == id && tbl[i].cyc == cyc) begin
               tag = $sformatf("run%0d.c%0d", id, cyc);
               check_vec(tbl[i], tag);
            end
         end
         if (wr_en) begin
            if (seen[wr_addr_a]) dup++;
            seen[wr_addr_a] = 1'b1;
            if (seen[wr_addr_b]) dup++;
            seen[wr_addr_b] = 1'b1;
            wcnt++;
            if (wcnt % 128 == 0) begin
               chk($sformatf("run%0d.layer%0d_cover", id, wcnt / 128 - 1), $countones(seen), 256);
               seen = '0;
            end
         end
         if (busy && bf_mode !== {1'b0, inv_v}) bad_mode++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (cyc == 200 || cyc == 931) begin
            start = 1'b1;
            inv   = ~inv_v;
         end else begin
            start = 1'b0;
            inv   = inv_v;
         end
         tick();
      end
      start = 1'b0;
      chk($sformatf("run%0d.done_cycle", id), done_cyc, 932);
      chk($sformatf("run%0d.done_pulses", id), done_cnt, 1);
      chk($sformatf("run%0d.total_writes", id), wcnt, 896);
      chk($sformatf("run%0d.dup_writes", id), dup, 0);
      chk($sformatf("run%0d.bf_mode_busy", id), bad_mode, 0);
   endtask

   initial begin
      vec_t rv;
      int   dn;
      rv    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      rst   = 1'b1;
      start = 1'b0;
      inv   = 1'b0;
      abort = 1'b0;
      #3;
      check_vec(rv, "reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      //           run cyc  rd  a    b    tw   wr  wa   wb   bz dn md
      tbl.push_back(mk(0,   1, 1,   0, 128,   1, 0,   0,   0, 1, 0, 0));
      tbl.push_back(mk(0,   6, 1,   5, 133,   1, 1,   0, 128, 1, 0, 0));
      tbl.push_back(mk(0, 128, 1, 127, 255,   1, 1, 122, 250, 1, 0, 0));
      tbl.push_back(mk(0, 129, 0,   0,   0,   0, 1, 123, 251, 1, 0, 0));
      tbl.push_back(mk(0, 133, 0,   0,   0,   0, 1, 127, 255, 1, 0, 0));
      tbl.push_back(mk(0, 134, 1,   0,  64,   2, 0,   0,   0, 1, 0, 0));
      tbl.push_back(mk(0, 198, 1, 128, 192,   3, 1,  59, 123, 1, 0, 0));
      tbl.push_back(mk(0, 437, 1,  69,  85,  10, 1,  64,  80, 1, 0, 0));
      tbl.push_back(mk(0, 799, 1,   0,   2,  64, 0,   0,   0, 1, 0, 0));
      tbl.push_back(mk(0, 800, 1,   1,   3,  64, 0,   0,   0, 1, 0, 0));
      tbl.push_back(mk(0, 926, 1, 253, 255, 127, 1, 244, 246, 1, 0, 0));
      tbl.push_back(mk(0, 931, 0,   0,   0,   0, 1, 253, 255, 1, 0, 0));
      tbl.push_back(mk(0, 932, 0,   0,   0,   0, 0,   0,   0, 0, 1, 3));
      tbl.push_back(mk(0, 933, 0,   0,   0,   0, 0,   0,   0, 0, 0, 3));
      tbl.push_back(mk(1,   1, 1,   0,   2, 127, 0,   0,   0, 1, 0, 1));
      tbl.push_back(mk(1,   2, 1,   1,   3, 127, 0,   0,   0, 1, 0, 1));
      tbl.push_back(mk(1, 276, 1,  17,  25,  30, 1,   4,  12, 1, 0, 1));
      tbl.push_back(mk(1, 799, 1,   0, 128,   1, 0,   0,   0, 1, 0, 1));
      tbl.push_back(mk(1, 926, 1, 127, 255,   1, 1, 122, 250, 1, 0, 1));
      tbl.push_back(mk(1, 932, 0,   0,   0,   0, 0,   0,   0, 0, 1, 3));

      tick();
      do_run(0, 1'b0);
      do_run(1, 1'b1);

      // Abort in layer 2 RUN, while writes are in flight.
      cyc = 0; dn = 0;
      start = 1'b1; inv = 1'b0;
      tick();
      start = 1'b0;
      while (cyc < 300) begin
         if (done) dn++;
         tick();
      end
      chk("abort.pre_wr_en", int'(wr_en), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort.busy", int'(busy), 0);
      chk("abort.rd_en", int'(rd_en), 0);
      chk("abort.wr_en", int'(wr_en), 0);
      chk("abort.bf_mode", int'(bf_mode), 3);
      repeat (20) begin
         if (done || wr_en || rd_en) dn++;
         tick();
      end
      chk("abort.no_activity", dn, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle.busy", int'(busy), 0);

      // start and abort together in IDLE: start wins.
      cyc = 0;
      start = 1'b1; abort = 1'b1; inv = 1'b0;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort.rd_en", int'(rd_en), 1);
      chk("start_abort.rd_addr_b", int'(rd_addr_b), 128);
      chk("start_abort.busy", int'(busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("start_abort.cancel", int'(busy), 0);
      repeat (3) tick();

      // Asynchronous reset in layer 0 DRAIN while writes drain.
      cyc = 0;
      start = 1'b1; inv = 1'b1;
      tick();
      start = 1'b0;
      while (cyc < 130) tick();
      chk("rst.pre_wr_en", int'(wr_en), 1);
      rst = 1'b1;
      #1;
      check_vec(rv, "rst_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      dn = 0;
      repeat (1000) begin
         if (done || busy || wr_en) dn++;
         tick();
      end
      chk("rst.no_resume", dn, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
